// File: rtl/alu_nbit_seq_pkg.sv
// Shared definitions for the sequential N-bit ALU: op codes, FSM states,
// and a helper that identifies the iterative shift operations.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_nbit_seq_if.sv
// Operand/result bus of the sequential ALU: input and output valid/ready
// handshakes plus operands, control and registered result/flags.
interface alu_nbit_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ainvert;
    logic             binvert;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    // ALU side
    modport slave (
        input  in_valid, a, b, cin, ainvert, binvert, op, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, neg
    );

    // Producer/consumer side
    modport master (
        output in_valid, a, b, cin, ainvert, binvert, op, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, neg
    );
endinterface

// File: rtl/alu_nbit_seq_core.sv
// Combinational single-cycle ALU slice: optional operand inversion,
// AND/OR/XOR/ADD/SLT with carry and signed overflow. Shifts yield zero here.
module alu_nbit_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             ainvert,
    input  logic             binvert,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH-1:0] ap;
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   sum;
    logic             add_ovf;

    assign ap      = a ^ {WIDTH{ainvert}};
    assign bp      = b ^ {WIDTH{binvert}};
    assign sum     = {1'b0, ap} + {1'b0, bp} + {{WIDTH{1'b0}}, cin};
    assign add_ovf = (ap[WIDTH-1] == bp[WIDTH-1]) && (sum[WIDTH-1] != ap[WIDTH-1]);

    // Operation select; only ADD and SLT report carry/overflow
    always_comb begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        unique case (op)
            OP_AND: result = ap & bp;
            OP_OR:  result = ap | bp;
            OP_XOR: result = ap ^ bp;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
                ovf    = add_ovf;
            end
            OP_SLT: begin
                result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
                cout   = sum[WIDTH];
                ovf    = add_ovf;
            end
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_nbit_seq.sv
// Sequential WIDTH-bit ALU: single-cycle logic/arith ops, one-bit-per-cycle
// shifts, registered result/flags and valid/ready handshakes on both sides.
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_nbit_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   res_q, res_n;
    logic               cout_q, cout_n;
    logic               ovf_q, ovf_n;
    logic               zero_q, zero_n;
    logic               neg_q, neg_n;
    logic [SHAMT_W-1:0] cnt_q, cnt_n;
    logic [2:0]         sh_op_q, sh_op_n;
    logic               upd;

    logic [WIDTH-1:0]   core_res;
    logic               core_cout;
    logic               core_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               shift_start;

    alu_nbit_core #(.WIDTH(WIDTH)) u_core (
        .a       (bus.a),
        .b       (bus.b),
        .cin     (bus.cin),
        .ainvert (bus.ainvert),
        .binvert (bus.binvert),
        .op      (bus.op),
        .result  (core_res),
        .cout    (core_cout),
        .ovf     (core_ovf)
    );

    assign shamt       = bus.b[SHAMT_W-1:0];
    assign bus.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready;
    assign shift_start = is_shift(bus.op) && (shamt != '0);

    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state: DONE can retire and accept in the same edge
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_n = shift_start ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) state_n = ST_DONE;
            end
            ST_DONE: begin
                if (accept)              state_n = shift_start ? ST_SHIFT : ST_DONE;
                else if (bus.out_ready)  state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Datapath next values; the result register doubles as the shift register
    always_comb begin
        res_n   = res_q;
        cout_n  = cout_q;
        ovf_n   = ovf_q;
        cnt_n   = cnt_q;
        sh_op_n = sh_op_q;
        upd     = 1'b0;
        if (accept) begin
            upd = 1'b1;
            if (is_shift(bus.op)) begin
                res_n   = bus.a;
                cout_n  = 1'b0;
                ovf_n   = 1'b0;
                cnt_n   = shamt;
                sh_op_n = bus.op;
            end else begin
                res_n   = core_res;
                cout_n  = core_cout;
                ovf_n   = core_ovf;
                cnt_n   = '0;
            end
        end else if (state == ST_SHIFT) begin
            upd   = 1'b1;
            ovf_n = 1'b0;
            cnt_n = cnt_q - SHAMT_W'(1);
            unique case (sh_op_q)
                OP_SLL: begin
                    cout_n = res_q[WIDTH-1];
                    res_n  = {res_q[WIDTH-2:0], 1'b0};
                end
                OP_SRL: begin
                    cout_n = res_q[0];
                    res_n  = {1'b0, res_q[WIDTH-1:1]};
                end
                default: begin
                    cout_n = res_q[0];
                    res_n  = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
                end
            endcase
        end
        // Flags are registered alongside the result so they clear on reset
        zero_n = upd ? (res_n == '0)      : zero_q;
        neg_n  = upd ? res_n[WIDTH-1]     : neg_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            sh_op_q <= '0;
        end else begin
            res_q   <= res_n;
            cout_q  <= cout_n;
            ovf_q   <= ovf_n;
            zero_q  <= zero_n;
            neg_q   <= neg_n;
            cnt_q   <= cnt_n;
            sh_op_q <= sh_op_n;
        end
    end
endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed and randomised checks of alu_nbit_seq at WIDTH=16.
module tb_alu_nbit_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    alu_nbit_seq_if #(.WIDTH(W)) bus ();

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic [3:0]   f;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [3:0] flags();
        return {bus.cout, bus.ovf, bus.zero, bus.neg};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic c, input logic ai, input logic bi);
        bus.op = o; bus.a = aa; bus.b = bb;
        bus.cin = c; bus.ainvert = ai; bus.binvert = bi;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    // Reference model: {result, cout, ovf, zero, neg}
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic c, input logic ai, input logic bi);
        logic [W-1:0] ap, bp, r;
        logic [W:0]   s;
        logic         co, ov;
        int unsigned  sh;
        exp_t         e;
        ap = ai ? ~aa : aa;
        bp = bi ? ~bb : bb;
        s  = ap + bp + c;
        ov = (ap[W-1] == bp[W-1]) && (s[W-1] != ap[W-1]);
        sh = bb[3:0];
        r = '0; co = 1'b0;
        case (o)
            3'b000: begin r = ap & bp; ov = 1'b0; end
            3'b001: begin r = ap | bp; ov = 1'b0; end
            3'b100: begin r = ap ^ bp; ov = 1'b0; end
            3'b010: begin r = s[W-1:0]; co = s[W]; end
            3'b011: begin r = {15'd0, s[W-1] ^ ov}; co = s[W]; end
            3'b101: begin r = aa << sh; co = (sh == 0) ? 1'b0 : aa[W-sh]; ov = 1'b0; end
            3'b110: begin r = aa >> sh; co = (sh == 0) ? 1'b0 : aa[sh-1]; ov = 1'b0; end
            default: begin r = $signed(aa) >>> sh; co = (sh == 0) ? 1'b0 : aa[sh-1]; ov = 1'b0; end
        endcase
        e.r = r;
        e.f = {co, ov, (r == '0), r[W-1]};
        return e;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t         q[$];
        exp_t         e;
        int           n;
        int           issued;
        int           retired;
        logic         fired;
        logic         hold_seen;
        logic [W-1:0] hold_val;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.op = '0;
        bus.cin = 1'b0; bus.ainvert = 1'b0; bus.binvert = 1'b0;
        step(); step();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", flags(), 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        step();

        // ADD with signed overflow, 1-cycle latency
        issue(3'b010, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("add_valid_k1", bus.out_valid, 1);
        check("add_result", bus.result, 16'h8000);
        check("add_flags", flags(), 4'b0101);
        retire();
        check("add_retired", bus.out_valid, 0);

        // SUB equal operands
        issue(3'b010, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1);
        check("sub_result", bus.result, 16'h0000);
        check("sub_flags", flags(), 4'b1010);
        retire();

        // SLT -2 < 1 as subtraction
        issue(3'b011, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b1);
        check("slt_result", bus.result, 16'h0001);
        check("slt_flags", flags(), 4'b1000);
        retire();

        // Logic ops with inversion
        issue(3'b100, 16'h00FF, 16'h0F0F, 1'b0, 1'b1, 1'b0);
        check("xor_ainv_result", bus.result, 16'hF00F);
        check("xor_ainv_flags", flags(), 4'b0001);
        retire();
        issue(3'b000, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0);
        check("and_result", bus.result, 16'hF000);
        retire();

        // SRA by 4: busy for 4 cycles, valid exactly 5 cycles after accept
        issue(3'b111, 16'h8010, 16'h0004, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check("sra_busy_valid", bus.out_valid, 0);
            check("sra_busy_in_ready", bus.in_ready, 0);
            if (i < 4) step();
        end
        step();
        check("sra_valid_k5", bus.out_valid, 1);
        check("sra_result", bus.result, 16'hF801);
        check("sra_flags", flags(), 4'b0001);

        // Back-pressure: result held, not ready for input
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold", {bus.out_valid, bus.in_ready, bus.result}, {1'b1, 1'b0, 16'hF801});
        end
        bus.out_ready = 1'b1;
        bus.op = 3'b001; bus.a = 16'h00F0; bus.b = 16'h0F0F;
        bus.cin = 1'b0; bus.ainvert = 1'b0; bus.binvert = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        check("bp_release_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("bp_new_valid", bus.out_valid, 1);
        check("bp_new_result", bus.result, 16'h0FFF);
        retire();

        // Shift boundaries: shamt 0 and 1, and WIDTH-1
        issue(3'b101, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("sll0_valid_k1", bus.out_valid, 1);
        check("sll0_result", {bus.result, flags()}, {16'h8001, 4'b0001});
        retire();
        issue(3'b110, 16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("srl1_valid_early", bus.out_valid, 0);
        step();
        check("srl1_result", {bus.out_valid, bus.result, flags()}, {1'b1, 16'h4000, 4'b1000});
        retire();
        issue(3'b101, 16'h0003, 16'h000F, 1'b0, 1'b0, 1'b0);
        wait_valid(n);
        check("sll15_cycles", n, 15);
        check("sll15_result", {bus.result, flags()}, {16'h8000, 4'b1001});
        retire();

        // Reset in the middle of a long shift
        issue(3'b101, 16'h1234, 16'h000F, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst_n = 1'b0;
        step();
        check("midrst_state", {bus.out_valid, bus.in_ready, bus.result, flags()}, {1'b0, 1'b1, 16'h0000, 4'b0000});
        rst_n = 1'b1;
        issue(3'b010, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        check("post_rst_add", {bus.out_valid, bus.result}, {1'b1, 16'h0003});
        retire();

        // Random stream against the reference model
        issued = 0; retired = 0; hold_seen = 1'b0; hold_val = '0;
        for (int cyc = 0; cyc < 4000 && (issued < 40 || q.size() > 0); cyc++) begin
            if (!bus.in_valid && issued < 40 && $urandom_range(0, 2) != 0) begin
                bus.op = 3'($urandom_range(0, 7));
                bus.a = 16'($urandom); bus.b = 16'($urandom);
                bus.cin = 1'($urandom_range(0, 1));
                bus.ainvert = 1'($urandom_range(0, 1));
                bus.binvert = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (hold_seen && bus.out_valid)
                check("rnd_hold_stable", bus.result, hold_val);
            hold_seen = bus.out_valid && !bus.out_ready;
            hold_val  = bus.result;
            if (bus.out_valid && bus.out_ready) begin
                check("rnd_queue_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("rnd_result", bus.result, e.r);
                    check("rnd_flags", flags(), e.f);
                end
                retired++;
            end
            fired = bus.in_valid && bus.in_ready;
            if (fired) begin
                q.push_back(model(bus.op, bus.a, bus.b, bus.cin, bus.ainvert, bus.binvert));
                issued++;
            end
            step();
            if (fired) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        check("rnd_issued", issued, 40);
        check("rnd_retired", retired, issued);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
